inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage directly upstream of the instruction ROM: owns the program counter (PC)
//  and drives the ROM address. Captures the returned instruction into a registered IR for decode.
//  Handles Start/Done, stall, taken branches (flushing the wrong-path fetch) and halt detection.
// PARAMETERS
//  A        10     PC / ROM address width
//  W        9      instruction width
//  HALT_OP  '1     instruction encoding that halts fetch (all ones, 9'h1FF)
// PORTS
//  Clk          in   1  clock, all state on rising edge
//  Reset        in   1  asynchronous, active-high reset
//  Start        in   1  level; while high, PC held at 0 and state forced to IDLE
//  Stall        in   1  decode/execute not ready; hold PC and IR
//  BranchTaken  in   1  execute resolved a taken branch on the current IR
//  BranchIdx    in   3  index into branch-target LUT (valid with BranchTaken)
//  InstIn       in   W  ROM data, combinational from InstAddress
//  InstAddress  out  A  ROM address (= PC, registered)
//  IrOut        out  W  registered instruction to decode
//  IrValid      out  1  IrOut holds a valid, non-flushed instruction
//  Done         out  1  program halted; sticky until Start or Reset
// BEHAVIOUR
//  Reset (async): state=IDLE, PC=0, IrOut=0, IrValid=0, Done=0.
//  States: IDLE -> RUN -> HALT.
//   IDLE: PC=0, IrValid=0. Goes to RUN on the first edge with Start=0.
//         First fetch is address 0 in the first RUN cycle.
//   RUN: each edge, first matching rule applies (priority order):
//    1 Start=1: ->IDLE, PC=0, IrValid=0, Done=0.
//    2 BranchTaken=1: PC=lut[BranchIdx], IrValid=0 (flush fetch at old PC).
//      Halt on that same fetch is ignored; branch wins over halt and Stall.
//    3 Stall=1: PC, IrOut, IrValid unchanged. Halt detection deferred.
//    4 InstIn==HALT_OP: ->HALT, IrValid=0, PC unchanged, Done=1 next cycle (registered).
//    5 else: IrOut=InstIn, IrValid=1, PC=PC+1.
//  HALT: PC, IrOut frozen, IrValid=0, Done=1. BranchTaken/Stall ignored.
//        Start=1 -> IDLE, Done=0.
//  Arithmetic: PC+1 is modulo 2**A, so 2**A-1 wraps to 0 with no flag.
//              LUT targets are A-bit absolute addresses.
//  Latency: address->IrOut = 1 cycle. Branch penalty = 1 bubble cycle (IrValid=0).
//  Reset asserted mid-run: immediate return to reset values, no edge required.
//  Start=1 in any state overrides everything except Reset.
// STRUCTURE
//  Package fetch_pkg:
//   - typedef enum logic[1:0] {IDLE,RUN,HALT} fetch_state_t
//   - localparam HALT_OP
//   - localparam BR_LUT[8] = {0,8,16,32,64,128,256,512}
//  Sub-module branch_lut: combinational 3->A lookup of BR_LUT. Reused by the assembler-facing decode.
//  inst_fetch: state register, PC register, IR/IrValid registers, Done register.
// TESTING
//  1 Reset mid-RUN at PC=5 -> PC=0, IrValid=0, Done=0, IDLE, same cycle as Reset rises.
//  2 Start 1->0, ROM {0:9'h011,1:9'h022,2:9'h1FF} -> IrOut 011,022 on cycles 2,3.
//    Done=1 by cycle 5, PC frozen at 2.
//  3 BranchTaken=1, BranchIdx=3 while PC=1 -> next PC=32, one IrValid=0 bubble,
//    then IrOut=ROM[32].
//  4 Halt word fetched with BranchTaken=1 (idx 2) same cycle -> no halt, PC=16, Done stays 0.
//  5 Stall held 3 cycles at PC=4 -> PC, IrOut, IrValid unchanged; resumes at PC=5 after release.
//  6 PC=1023 normal fetch -> PC wraps to 0; Start=1 in HALT -> Done=0, IDLE, PC=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, halt opcode and
// the fixed branch-target table.
package fetch_pkg;

   localparam int ADDR_W = 10;
   localparam int INST_W = 9;

   typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;

   localparam logic [INST_W-1:0] HALT_OP = '1;

   localparam logic [ADDR_W-1:0] BR_LUT [8] = '{
      10'd0, 10'd8, 10'd16, 10'd32, 10'd64, 10'd128, 10'd256, 10'd512
   };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup: 3-bit index to absolute A-bit address.
module branch_lut
   import fetch_pkg::*;
#(
   parameter int A = ADDR_W
)
(
   input  logic [2:0]   idx,
   output logic [A-1:0] target
);

   assign target = A'(BR_LUT[idx]);

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC (ROM address), registers the returned instruction
// into the IR, and handles start, stall, taken branches and halt detection.
module inst_fetch
   import fetch_pkg::*;
#(
   parameter int A = ADDR_W,
   parameter int W = INST_W
)
(
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic         Stall,
   input  logic         BranchTaken,
   input  logic [2:0]   BranchIdx,
   input  logic [W-1:0] InstIn,
   output logic [A-1:0] InstAddress,
   output logic [W-1:0] IrOut,
   output logic         IrValid,
   output logic         Done
);

   fetch_state_t state_reg;
   logic [A-1:0] pc_reg;
   logic [A-1:0] br_target;

   branch_lut #(.A(A)) u_branch_lut (
      .idx    (BranchIdx),
      .target (br_target)
   );

   assign InstAddress = pc_reg;

   // Start overrides every state; within RUN the priority is branch, stall, halt, fetch.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         IrOut     <= '0;
         IrValid   <= 1'b0;
         Done      <= 1'b0;
      end else if (Start) begin
         state_reg <= IDLE;
         pc_reg    <= '0;
         IrValid   <= 1'b0;
         Done      <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg <= RUN;
               pc_reg    <= '0;
               IrValid   <= 1'b0;
            end
            RUN: begin
               if (BranchTaken) begin
                  // The instruction fetched at the old PC is wrong-path: drop it.
                  pc_reg  <= br_target;
                  IrValid <= 1'b0;
               end else if (Stall) begin
                  pc_reg  <= pc_reg;
               end else if (InstIn == HALT_OP) begin
                  state_reg <= HALT;
                  IrValid   <= 1'b0;
                  Done      <= 1'b1;
               end else begin
                  IrOut   <= InstIn;
                  IrValid <= 1'b1;
                  pc_reg  <= pc_reg + A'(1);
               end
            end
            HALT: begin
               IrValid <= 1'b0;
               Done    <= 1'b1;
            end
            default: begin
               state_reg <= IDLE;
               pc_reg    <= '0;
               IrValid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random traffic,
// all compared every cycle against a behavioural model of the fetch rules.
module tb_inst_fetch;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Stall;
   logic       BranchTaken;
   logic [2:0] BranchIdx;
   logic [8:0] InstIn;
   logic [9:0] InstAddress;
   logic [8:0] IrOut;
   logic       IrValid;
   logic       Done;

   logic [8:0] rom [1024];

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // behavioural model state
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
   int m_state, m_pc, m_ir, m_valid, m_done;

   inst_fetch dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Stall       (Stall),
      .BranchTaken (BranchTaken),
      .BranchIdx   (BranchIdx),
      .InstIn      (InstIn),
      .InstAddress (InstAddress),
      .IrOut       (IrOut),
      .IrValid     (IrValid),
      .Done        (Done)
   );

   assign InstIn = rom[InstAddress];

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int lut_target(input int idx);
      return (idx == 0) ? 0 : (1 << (idx + 2));
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_pc = 0; m_ir = 0; m_valid = 0; m_done = 0;
   endtask

   // One clock edge of the fetch rules, using the inputs present at that edge.
   task automatic model_step();
      int inst;
      if (Reset) begin
         model_reset();
      end else if (Start) begin
         m_state = M_IDLE; m_pc = 0; m_valid = 0; m_done = 0;
      end else if (m_state == M_IDLE) begin
         m_state = M_RUN;
      end else if (m_state == M_RUN) begin
         inst = int'(rom[m_pc]);
         if (BranchTaken) begin
            m_pc = lut_target(int'(BranchIdx));
            m_valid = 0;
         end else if (Stall) begin
            // nothing moves
         end else if (inst == 511) begin
            m_state = M_HALT; m_valid = 0; m_done = 1;
         end else begin
            m_ir = inst; m_valid = 1; m_pc = (m_pc + 1) % 1024;
         end
      end
   endtask

   // Compare process: outputs are checked on every falling edge once armed.
   always @(negedge Clk) begin
      if (chk_en) begin
         chk("pc",    int'(InstAddress), m_pc);
         chk("valid", int'(IrValid),     m_valid);
         chk("done",  int'(Done),        m_done);
         chk("ir",    int'(IrOut),       m_ir);
      end
   end

   task automatic step(input logic st, input logic stl, input logic br, input logic [2:0] idx);
      Start = st; Stall = stl; BranchTaken = br; BranchIdx = idx;
      @(posedge Clk);
      model_step();
      @(negedge Clk);
   endtask

   task automatic rom_plain();
      for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom_range(0, 510));
   endtask

   initial begin
      logic [8:0] held_ir;
      Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchIdx = 3'd0;
      rom_plain();
      model_reset();
      @(negedge Clk);
      chk("reset_pc",    int'(InstAddress), 0);
      chk("reset_valid", int'(IrValid),     0);
      chk("reset_done",  int'(Done),        0);
      chk("reset_ir",    int'(IrOut),       0);
      Reset = 1'b0;
      chk_en = 1;

      // Start release, two fetches, then halt word at address 2
      rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h1FF;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t2_ir0", int'(IrOut), 9'h011);
      step(0, 0, 0, 0);
      chk("t2_ir1", int'(IrOut), 9'h022);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t2_done", int'(Done), 1);
      chk("t2_pc",   int'(InstAddress), 2);

      // Taken branch idx 3 at PC=1 -> 32 with one bubble
      rom[2] = 9'h033; rom[32] = 9'h0A5;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t3_pc1", int'(InstAddress), 1);
      step(0, 0, 1, 3'd3);
      chk("t3_pc_tgt", int'(InstAddress), 32);
      chk("t3_bubble", int'(IrValid), 0);
      step(0, 0, 0, 0);
      chk("t3_ir", int'(IrOut), 9'h0A5);
      chk("t3_valid", int'(IrValid), 1);

      // Halt word fetched together with a branch: branch wins
      rom[33] = 9'h1FF;
      step(0, 0, 1, 3'd2);
      chk("t4_pc",   int'(InstAddress), 16);
      chk("t4_done", int'(Done), 0);
      rom[33] = 9'h044;

      // Stall held 3 cycles at PC=4
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      chk("t5_pc4", int'(InstAddress), 4);
      held_ir = IrOut;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         chk("t5_stall_pc", int'(InstAddress), 4);
         chk("t5_stall_ir", int'(IrOut), int'(held_ir));
         chk("t5_stall_valid", int'(IrValid), 1);
      end
      step(0, 0, 0, 0);
      chk("t5_resume_pc", int'(InstAddress), 5);

      // Asynchronous reset mid-run at PC=5, seen before any clock edge
      #2 Reset = 1'b1;
      #1;
      chk("t1_pc",    int'(InstAddress), 0);
      chk("t1_valid", int'(IrValid), 0);
      chk("t1_done",  int'(Done), 0);
      model_reset();
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      Reset = 1'b0;

      // Wrap from 1023 to 0, halt at 0, Start in HALT
      step(0, 0, 0, 0);
      step(0, 0, 1, 3'd7);
      chk("t6_pc512", int'(InstAddress), 512);
      for (int i = 0; i < 512; i++) step(0, 0, 0, 0);
      chk("t6_wrap", int'(InstAddress), 0);
      rom[0] = 9'h1FF;
      step(0, 0, 0, 0);
      chk("t6_done", int'(Done), 1);
      step(0, 1, 1, 3'd5);
      chk("t6_frozen", int'(InstAddress), 0);
      step(1, 0, 0, 0);
      chk("t6_done_clr", int'(Done), 0);
      chk("t6_pc0", int'(InstAddress), 0);

      // Random traffic with occasional halt words in the ROM
      for (int i = 0; i < 1024; i++)
         rom[i] = ($urandom_range(0, 39) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)));
      end

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
